// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite control register slave: register map,
// response codes, FSM state encoding and the byte-strobe expansion helper.
package axil_pkg;

    localparam logic [31:0] CTRL_OFS     = 32'h000;
    localparam logic [31:0] STATUS_OFS   = 32'h004;
    localparam logic [31:0] IRQ_STAT_OFS = 32'h008;
    localparam logic [31:0] IRQ_EN_OFS   = 32'h00C;
    localparam logic [31:0] USER_BASE    = 32'h010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_BR,
        ST_RA,
        ST_RD
    } axil_state_e;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_IRQ_STAT,
        SEL_IRQ_EN,
        SEL_USER,
        SEL_NONE
    } reg_sel_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/axil_slave_fsm.sv
// AXI4-Lite handshake engine: serialises one read or write at a time and
// presents a single-cycle write commit / read request to the register file.
module axil_slave_fsm
    import axil_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              wr_commit_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    input  logic              wr_err_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_err_i
);

    axil_state_e       state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q, rresp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Write has priority over read when both arrive in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) state_d = ST_BR;
                else if (S_AXI_AWVALID)            state_d = ST_AW;
                else if (S_AXI_WVALID)             state_d = ST_W;
                else if (S_AXI_ARVALID)            state_d = ST_RA;
            end
            ST_AW:   if (S_AXI_WVALID)  state_d = ST_BR;
            ST_W:    if (S_AXI_AWVALID) state_d = ST_BR;
            ST_BR:   if (S_AXI_BREADY)  state_d = ST_IDLE;
            ST_RA:   state_d = ST_RD;
            ST_RD:   if (S_AXI_RREADY)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = (state_q == ST_IDLE) || (state_q == ST_W);
        S_AXI_WREADY  = (state_q == ST_IDLE) || (state_q == ST_AW);
        S_AXI_ARREADY = (state_q == ST_IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;
        S_AXI_BVALID  = (state_q == ST_BR);
        S_AXI_RVALID  = (state_q == ST_RD);
        S_AXI_BRESP   = bresp_q;
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
        // Commit fires only on the transition into BR, so a stalled BREADY cannot repeat it.
        wr_commit_o   = (state_q != ST_BR) && (state_d == ST_BR);
        wr_addr_o     = (state_q == ST_AW) ? awaddr_q : S_AXI_AWADDR;
        wr_data_o     = (state_q == ST_W)  ? wdata_q  : S_AXI_WDATA;
        wr_strb_o     = (state_q == ST_W)  ? wstrb_q  : S_AXI_WSTRB;
        rd_req_o      = (state_q == ST_RA);
        rd_addr_o     = araddr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (state_q == ST_IDLE && S_AXI_AWVALID) awaddr_q <= S_AXI_AWADDR;
            if (state_q == ST_IDLE && S_AXI_WVALID) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) araddr_q <= S_AXI_ARADDR;
            if (wr_commit_o) bresp_q <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
            if (rd_req_o) begin
                rdata_q <= rd_data_i;
                rresp_q <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control/status register file for the accelerator: control levels,
// start pulse, live status, sticky W1C events with interrupt, user scratch regs.
module axil_ctrl_regs
    import axil_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int NUM_USER = 4,
    parameter int NUM_EVT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  matw,
    output logic                  run,
    output logic                  last,
    output logic                  start,
    output logic [32*NUM_USER-1:0] user_regs,
    input  logic [31:0]           status_in,
    input  logic [NUM_EVT-1:0]    event_in,
    output logic                  irq
);

    localparam int UIDX_W = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;

    logic              wr_commit, wr_err, rd_req, rd_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data, wmask;
    logic [3:0]        wr_strb;
    reg_sel_e          wsel, rsel;
    logic [UIDX_W-1:0] widx, ridx;

    logic [2:0]         ctrl_q, ctrl_d;
    logic               start_q, start_d;
    logic [NUM_EVT-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, w1c;
    logic               irq_q;
    logic [31:0]        user_q [NUM_USER];
    logic [31:0]        user_d [NUM_USER];

    axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .wr_commit_o   (wr_commit),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_strb_o     (wr_strb),
        .wr_err_i      (wr_err),
        .rd_req_o      (rd_req),
        .rd_addr_o     (rd_addr),
        .rd_data_i     (rd_data),
        .rd_err_i      (rd_err)
    );

    function automatic reg_sel_e decode_sel(input logic [ADDR_W-1:0] addr);
        logic [31:0] a;
        a = 32'(addr) & ~32'h3;
        if (a == CTRL_OFS)     return SEL_CTRL;
        if (a == STATUS_OFS)   return SEL_STATUS;
        if (a == IRQ_STAT_OFS) return SEL_IRQ_STAT;
        if (a == IRQ_EN_OFS)   return SEL_IRQ_EN;
        if (a >= USER_BASE && a < USER_BASE + 32'(4 * NUM_USER)) return SEL_USER;
        return SEL_NONE;
    endfunction

    function automatic logic [UIDX_W-1:0] decode_idx(input logic [ADDR_W-1:0] addr);
        logic [31:0] ofs;
        ofs = 32'(addr) - USER_BASE;
        return UIDX_W'(ofs >> 2);
    endfunction

    always_comb begin
        wsel     = decode_sel(wr_addr);
        widx     = decode_idx(wr_addr);
        wmask    = strb_mask(wr_strb);
        wr_err   = (wsel == SEL_NONE);
        ctrl_d   = ctrl_q;
        start_d  = 1'b0;
        irq_en_d = irq_en_q;
        w1c      = '0;
        user_d   = user_q;
        if (wr_commit) begin
            case (wsel)
                SEL_CTRL: begin
                    if (wr_strb[0]) ctrl_d = wr_data[2:0];
                    start_d = wr_strb[1] && wr_data[8];
                end
                SEL_IRQ_STAT: w1c = wr_data[NUM_EVT-1:0] & wmask[NUM_EVT-1:0];
                SEL_IRQ_EN:   irq_en_d = (irq_en_q & ~wmask[NUM_EVT-1:0])
                                       | (wr_data[NUM_EVT-1:0] & wmask[NUM_EVT-1:0]);
                SEL_USER:     user_d[widx] = (user_q[widx] & ~wmask) | (wr_data & wmask);
                default: ;
            endcase
        end
        // A new event in the same cycle as its W1C clear keeps the bit set.
        irq_stat_d = (irq_stat_q & ~w1c) | event_in;
    end

    always_comb begin
        rsel    = decode_sel(rd_addr);
        ridx    = decode_idx(rd_addr);
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_req) begin
            rd_err = (rsel == SEL_NONE);
            case (rsel)
                SEL_CTRL:     rd_data = {29'd0, ctrl_q};
                SEL_STATUS:   rd_data = status_in;
                SEL_IRQ_STAT: rd_data = 32'(irq_stat_q);
                SEL_IRQ_EN:   rd_data = 32'(irq_en_q);
                SEL_USER:     rd_data = user_q[ridx];
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            start_q    <= 1'b0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < NUM_USER; k++) user_q[k] <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            start_q    <= start_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
            for (int k = 0; k < NUM_USER; k++) user_q[k] <= user_d[k];
        end
    end

    for (genvar k = 0; k < NUM_USER; k++) begin : g_user
        assign user_regs[32*k +: 32] = user_q[k];
    end

    assign matw  = ctrl_q[0];
    assign run   = ctrl_q[1];
    assign last  = ctrl_q[2];
    assign start = start_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs: stimulus pushes expected B/R responses
// into a queue that a negedge monitor pops and compares on each handshake.
module tb_axil_ctrl_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  AWADDR, ARADDR;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;
    logic         matw, run, last, start, irq;
    logic [127:0] user_regs;
    logic [31:0]  status_in;
    logic [7:0]   event_in;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    logic irq_at_b, start_at_b;

    axil_ctrl_regs #(.ADDR_W(12), .NUM_USER(4), .NUM_EVT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .matw          (matw),
        .run           (run),
        .last          (last),
        .start         (start),
        .user_regs     (user_regs),
        .status_in     (status_in),
        .event_in      (event_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (!rst) begin
            if (BVALID && BREADY) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected B response: bresp=%0b, expected none", BRESP);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.nm, " order(is_rd)"}, {31'd0, mon_e.is_rd}, 32'd0);
                    chk({mon_e.nm, " bresp"}, {30'd0, BRESP}, {30'd0, mon_e.resp});
                end
            end
            if (RVALID && RREADY) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected R response: rdata=0x%08h, expected none", RDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.nm, " order(is_rd)"}, {31'd0, mon_e.is_rd}, 32'd1);
                    chk({mon_e.nm, " rresp"}, {30'd0, RRESP}, {30'd0, mon_e.resp});
                    chk({mon_e.nm, " rdata"}, RDATA, mon_e.data);
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp, input logic [7:0] evt, input string nm);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, hs_b;
        int cyc = 0;
        exp_q.push_back('{1'b0, resp, 32'h0, nm});
        BREADY   = 1'b0;
        event_in = evt;
        while (!(aw_done && w_done) && cyc < 40) begin
            AWADDR  = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(posedge clk); #1;
            event_in = '0;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({nm, " aw/w accepted"}, {30'd0, aw_done, w_done}, 32'd3);
        cyc = 0;
        BREADY = (b_dly == 0);
        @(negedge clk);
        chk({nm, " bvalid next cycle"}, {31'd0, BVALID}, 32'd1);
        irq_at_b   = irq;
        start_at_b = start;
        hs_b = BVALID && BREADY;
        while (!hs_b && cyc < 40) begin
            chk({nm, " bvalid held"}, {31'd0, BVALID}, 32'd1);
            @(posedge clk); #1;
            cyc++;
            BREADY = (cyc >= b_dly);
            @(negedge clk);
            hs_b = BVALID && BREADY;
        end
        chk({nm, " b handshake"}, {31'd0, hs_b}, 32'd1);
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input string nm);
        bit hs = 0;
        int cyc = 0;
        exp_q.push_back('{1'b1, resp, d, nm});
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        while (!hs && cyc < 40) begin
            @(negedge clk);
            hs = ARVALID && ARREADY;
            @(posedge clk); #1;
            cyc++;
        end
        ARVALID = 1'b0;
        chk({nm, " ar accepted"}, {31'd0, hs}, 32'd1);
        @(negedge clk);
        chk({nm, " rvalid low in decode cycle"}, {31'd0, RVALID}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " rvalid after 2 cycles"}, {31'd0, RVALID}, 32'd1);
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        bit hs;
        int cyc;
        rst = 1'b1;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        status_in = '0; event_in = '0;
        repeat (3) @(negedge clk);
        chk("reset bvalid", {31'd0, BVALID}, 32'd0);
        chk("reset rvalid", {31'd0, RVALID}, 32'd0);
        chk("reset ctrl levels", {29'd0, last, run, matw}, 32'd0);
        chk("reset start/irq", {30'd0, start, irq}, 32'd0);
        chk("reset user_regs zero", {31'd0, (user_regs == 128'd0)}, 32'd1);
        chk("reset rdata", RDATA, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        @(posedge clk); #1;

        // Basic CTRL write with AW and W together
        axi_write(12'h000, 32'h0000_0003, 4'hF, 0, 0, 0, 2'b00, 8'h0, "ctrl wr3");
        chk("ctrl levels after 0x3", {29'd0, last, run, matw}, 32'd3);
        axi_read(12'h000, 32'h0000_0003, 2'b00, "ctrl rd3");

        // USER[1]: AW leads W by 3 cycles, then W leads AW with a stalled BREADY
        axi_write(12'h014, 32'hDEAD_BEEF, 4'b0101, 0, 3, 0, 2'b00, 8'h0, "user1 aw-first");
        chk("user1 strobed", user_regs[63:32], 32'h00AD_00EF);
        axi_write(12'h014, 32'h1122_3344, 4'b1010, 3, 0, 4, 2'b00, 8'h0, "user1 w-first");
        chk("user1 merged", user_regs[63:32], 32'h11AD_33EF);
        axi_read(12'h014, 32'h11AD_33EF, 2'b00, "user1 rd");

        // start pulse, with BREADY stalled to prove a single commit
        cnt0 = start_cnt;
        axi_write(12'h000, 32'h0000_0106, 4'hF, 0, 0, 4, 2'b00, 8'h0, "ctrl start");
        chk("start high after commit", {31'd0, start_at_b}, 32'd1);
        chk("start pulse count", start_cnt - cnt0, 32'd1);
        chk("ctrl levels after 0x106", {29'd0, last, run, matw}, 32'd6);
        axi_read(12'h000, 32'h0000_0006, 2'b00, "ctrl rd6");
        cnt0 = start_cnt;
        axi_write(12'h000, 32'h0000_0105, 4'b0001, 0, 0, 0, 2'b00, 8'h0, "ctrl no-strb1");
        chk("no start without wstrb1", start_cnt - cnt0, 32'd0);
        chk("ctrl levels after 0x105", {29'd0, last, run, matw}, 32'd5);

        // Events and interrupt
        axi_write(12'h00C, 32'h0000_0008, 4'hF, 0, 0, 0, 2'b00, 8'h0, "irq_en wr");
        axi_read(12'h00C, 32'h0000_0008, 2'b00, "irq_en rd");
        chk("irq before event", {31'd0, irq}, 32'd0);
        event_in = 8'h08;
        @(posedge clk); #1;
        event_in = 8'h00;
        @(posedge clk); #1;
        chk("irq after event", {31'd0, irq}, 32'd1);
        axi_write(12'h008, 32'h0000_0008, 4'hF, 0, 0, 0, 2'b00, 8'h08, "w1c+event");
        axi_read(12'h008, 32'h0000_0008, 2'b00, "irq_stat set wins");
        chk("irq held", {31'd0, irq}, 32'd1);
        axi_write(12'h008, 32'h0000_0008, 4'hF, 0, 0, 0, 2'b00, 8'h0, "w1c alone");
        chk("irq still 1 at commit", {31'd0, irq_at_b}, 32'd1);
        chk("irq cleared one cycle later", {31'd0, irq}, 32'd0);
        axi_read(12'h008, 32'h0000_0000, 2'b00, "irq_stat cleared");

        // STATUS and last USER register
        status_in = 32'hA5A5_0F0F;
        axi_read(12'h004, 32'hA5A5_0F0F, 2'b00, "status rd");
        axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, 8'h0, "status wr");
        axi_write(12'h01C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 8'h0, "user3 wr");
        chk("user3 reg", user_regs[127:96], 32'hCAFE_F00D);
        axi_read(12'h01F, 32'hCAFE_F00D, 2'b00, "user3 rd low bits ignored");

        // Unmapped accesses
        axi_write(12'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10, 8'h0, "unmapped wr");
        chk("unmapped wr user1 intact", user_regs[63:32], 32'h11AD_33EF);
        chk("unmapped wr ctrl intact", {29'd0, last, run, matw}, 32'd5);
        axi_read(12'h3FC, 32'h0000_0000, 2'b10, "unmapped rd 3fc");
        axi_read(12'h020, 32'h0000_0000, 2'b10, "unmapped rd past user");

        // Simultaneous read and write: write must be served first
        exp_q.push_back('{1'b0, 2'b00, 32'h0, "prio wr"});
        exp_q.push_back('{1'b1, 2'b00, 32'h1234_5678, "prio rd"});
        ARADDR = 12'h018; ARVALID = 1'b1; RREADY = 1'b1;
        AWADDR = 12'h018; WDATA = 32'h1234_5678; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        BREADY = 1'b1;
        @(negedge clk);
        chk("prio arready low", {31'd0, ARREADY}, 32'd0);
        chk("prio awready high", {31'd0, AWREADY}, 32'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        hs = 0; cyc = 0;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = ARVALID && ARREADY;
            @(posedge clk); #1;
            cyc++;
        end
        ARVALID = 1'b0;
        chk("prio ar accepted", {31'd0, hs}, 32'd1);
        hs = 0; cyc = 0;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = RVALID && RREADY;
            @(posedge clk); #1;
            cyc++;
        end
        chk("prio r handshake", {31'd0, hs}, 32'd1);
        BREADY = 1'b0; RREADY = 1'b0;

        // Reset asserted while the write response is pending
        AWADDR = 12'h000; WDATA = 32'h0000_0007; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        chk("rst-test bvalid pending", {31'd0, BVALID}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst bvalid", {31'd0, BVALID}, 32'd0);
        chk("async rst rvalid", {31'd0, RVALID}, 32'd0);
        chk("async rst ctrl levels", {29'd0, last, run, matw}, 32'd0);
        chk("async rst start/irq", {30'd0, start, irq}, 32'd0);
        chk("async rst user_regs zero", {31'd0, (user_regs == 128'd0)}, 32'd1);
        chk("async rst rdata", RDATA, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(12'h000, 32'h0000_0000, 2'b00, "ctrl after rst");

        repeat (3) @(posedge clk);
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_ctrl_regs.md
Name: axil_ctrl_regs

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 2-register control slave in the accelerator top level.
- Supplies matw/run/last levels plus a self-clearing start pulse to the datapath controllers.
- Adds byte-strobe writes, a read-only status word, sticky W1C event bits with enable mask and interrupt, N user scratch registers, and SLVERR on unmapped addresses.
- Sits in the accelerator top level between the PS AXI-Lite master and mat_ctrl/src_ctrl/s_ctrl.

Parameters:
ADDR_W, 12, byte address width decoded (bits [1:0] ignored)
NUM_USER, 4, number of 32-bit user scratch registers (1..16)
NUM_EVT, 8, number of event/interrupt sources (1..32)

Ports:
clk  in  1  clock for AXI-Lite and all registers
rst  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  / S_AXI_AWREADY out 1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  / S_AXI_WREADY out 1  write data handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  / S_AXI_BREADY in 1  write response handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  / S_AXI_ARREADY out 1  read address handshake
S_AXI_RDATA  out  32  read data (registered)
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID  out  1  / S_AXI_RREADY in 1  read data handshake
matw, run, last  out  1 each  CTRL[0], CTRL[1], CTRL[2] levels
start  out  1  one-cycle pulse when CTRL[8] is written as 1
user_regs  out  32*NUM_USER  flattened scratch registers, reg 0 in LSBs
status_in  in  32  live status, sampled on read
event_in  in  NUM_EVT  one-cycle event pulses
irq  out  1  registered OR of (IRQ_STAT & IRQ_EN)

Behaviour:
- Register map:
  - 0x000 CTRL RW: [2:0] = {last, run, matw}; [8] = start, write-1 pulses and reads 0; other bits read 0.
  - 0x004 STATUS RO: returns status_in; writes ignored with OKAY.
  - 0x008 IRQ_STAT W1C: [NUM_EVT-1:0].
  - 0x00C IRQ_EN RW: [NUM_EVT-1:0].
  - 0x010 + 4*k: USER[k] RW, for k < NUM_USER.
  - Any other address: unmapped. Writes are dropped with BRESP=10; reads return 0 with RRESP=10.
- Reset (async, rst=1): state IDLE; all READY/VALID low except ARREADY/AWREADY/WREADY, which follow IDLE decode after release; all registers 0; RDATA 0; start 0; irq 0.
- State machine: IDLE, AW (address held), W (data held), BR (response), RA (read decode), RD (read data).
  - IDLE: AWREADY=WREADY=1; ARREADY=1 only when AWVALID=0 and WVALID=0 (write has priority).
  - IDLE with AW and W in the same cycle -> BR. AW only -> AW. W only -> W. AR only -> RA.
  - AW: WREADY=1; on WVALID -> BR. W: AWREADY=1; on AWVALID -> BR.
  - BR: BVALID=1; hold until BREADY, then -> IDLE.
  - RA: one cycle, RDATA/RRESP captured -> RD.
  - RD: RVALID=1; RDATA stable until RREADY, then -> IDLE.
- Write commit:
  - Happens on the edge entering BR, exactly once per transaction, regardless of how long BREADY stalls.
  - When BVALID is first seen high, the new value is already readable.
  - WSTRB byte-masks RW registers. W1C applies only within strobed bytes. start requires WSTRB[1]=1.
- start: high for exactly the cycle after commit. A write of CTRL with bit8=1 also updates [2:0] in the same commit.
- IRQ_STAT[i] is set by event_in[i]=1. If a W1C clear and an event hit the same bit in the same cycle, the set wins.
- irq updates one cycle after IRQ_STAT or IRQ_EN changes.
- Read latency: ARVALID accepted in IDLE -> RVALID 2 cycles later. STATUS is sampled in RA.
- No outstanding transactions; one of read or write is in flight at a time.
- rst asserted mid-transaction aborts it: no commit, no response.

Decomposition:
- Shared package axil_pkg: register offset localparams (CTRL_OFS, STATUS_OFS, IRQ_STAT_OFS, IRQ_EN_OFS, USER_BASE), RESP_OKAY/RESP_SLVERR constants, state encoding.
- One natural sub-module, axil_slave_fsm: handshake FSM that outputs wr_commit/wr_addr/wr_data/wr_strb and rd_req/rd_addr, and accepts rd_data/rd_err.
- The register file and decode stay in axil_ctrl_regs.

Test Plan:
- Reset release, write 0x000=0x00000003 with AW and W in the same cycle -> BVALID the next cycle with BRESP=00; matw=1, run=1, last=0; read 0x000 returns 0x00000003.
- AW sent 3 cycles before W, then a second write with W before AW, to USER[1] (0x014) with data 0xDEADBEEF and WSTRB=0b0101 -> user_regs[63:32]=0x00AD00EF; exactly one commit per write; BREADY held low 4 cycles -> BVALID holds and no double commit.
- Write 0x000=0x00000106 -> start high exactly 1 cycle; run=1, last=1; read back 0x00000006.
- Pulse event_in[3]; IRQ_EN=0x08 -> irq=1. Write 1 to IRQ_STAT bit 3 in the same cycle as a new event_in[3] -> bit stays 1. A later W1C alone -> irq=0 one cycle after.
- Write 0x100 and read 0x3FC (unmapped) -> BRESP=10, RRESP=10, RDATA=0; no register changes.
- Assert ARVALID and AWVALID+WVALID together in IDLE -> write is served first, then the read; assert rst during BR -> all outputs return to reset values immediately.
